execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the 5-stage MIPS pipeline: holds the ID/EX register, applies the forwarding selects and stall/flush controls from the hazard unit, computes the ALU result, and holds the EX/MEM register feeding the memory stage. It also exports the E-stage source registers and load flag that the hazard unit compares against M/W destinations, so the two blocks form a closed loop each cycle.

## Interface
Parameters:
- none; widths come from `common` (`u32`, `creg_addr_t` = 5 bits) and `pipes`.

Ports (clock and reset first):
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `hazard_data` in `hazard_data_t`: `forwardA`/`forwardB` (2b), `stallF`, `stallD`, `stallE`, `flushM`. Only `forward*`, `stallE` and `flushM` are used here.
- `dec` in `decode_bundle_t`: valid, pc, rs, rt, rs_val, rt_val, imm, shamt, alu_op, alu_src, write_reg, reg_write, mem_to_reg, mem_write.
- `w_result` in 32: final W-stage write-back value.
- `m_read_data` in 32: data-memory read value of the load currently in M.
- `rsE`, `rtE` out `creg_addr_t`: ID/EX source registers, sent to the hazard unit.
- `mem_to_reg_E` out 1: ID/EX load flag, sent to the hazard unit.
- `exm` out `exmem_t`: valid, pc, alu_result, write_data, write_reg, reg_write, mem_to_reg, mem_write. These are the EX/MEM register contents.

## Operation
- **ID/EX register**
  - Reset has top priority: the register clears to all-zero, which is a bubble.
  - Else if `stallE`=1, the register holds.
  - Else it loads `dec`. A `dec.valid`=0 loads as a bubble: reg_write, mem_write and mem_to_reg are forced to 0.
- **Operand forwarding** (combinational, per operand X ∈ {A←rs, B←rt}), by select value:
  - 00: the ID/EX register-file value.
  - 01: `w_result`.
  - 10: `exm.alu_result`.
  - 11: `m_read_data`.
  - Register 0 override: if the ID/EX source register is 0, the operand is 0 regardless of select.
- **ALU inputs**
  - srcA = fwdA.
  - srcB = `alu_src` ? imm : fwdB.
  - Store write_data = fwdB, taken before the alu_src mux.
- **ALU ops** (`alu_op_t`, 4 bits):
  - ADD, SUB: wrap modulo 2^32, no overflow trap.
  - AND, OR, XOR, NOR.
  - SLT (signed) and SLTU: result is 32'h1 or 32'h0.
  - SLL, SRL, SRA: shift srcB by shamt.
  - LUI: {imm[15:0], 16'h0}.
  - Undefined codes: result 0.
- **EX/MEM register**
  - Reset has top priority: clears to zero.
  - Else if `flushM`=1, loads a bubble: valid, reg_write, mem_write, mem_to_reg = 0; the data fields are don't-care and zeroed.
  - Else it loads the ALU result and the control fields from ID/EX.
  - `flushM` wins over normal loading, including when ID/EX is simultaneously stalled.

## Timing
- Reset: all `exm` fields, `rsE`, `rtE` and `mem_to_reg_E` are 0 in the cycle after reset is sampled high.
- Latency: `dec` sampled at edge N appears in ID/EX after N and in `exm` after N+1.
- Load-use stall (`stallE`=1 with `flushM`=1):
  - ID/EX holds.
  - One bubble enters M.
  - The next cycle the load sits in W and is forwarded via select 01.
- Reset mid-stall: reset overrides both stall and flush; the pipeline restarts empty.
- A bubble in ID/EX (valid=0) still propagates through EX/MEM as valid=0. No side effects.
- No combinational path from `hazard_data` to any registered output other than through the D inputs of the registers.

## Structure
- `pipes` package holds:
  - `alu_op_t` enum
  - `decode_bundle_t`
  - `idex_t`
  - `exmem_t`
  - ALU opcode constants
- `hazard_data_t` already lives in `pipes`.
- One sub-module: `alu` (combinational: srcA, srcB, shamt, alu_op → result).
- Registers and forwarding muxes stay in `execute_stage`.

## Test plan
- **Plain ADD:** rs_val=5, rt_val=7, ADD, reg_write=1, write_reg=3, no forwarding → `exm.alu_result`=12, `reg_write`=1 two edges after `dec` is presented; reset then zeroes all outputs.
- **M/W forwarding:** forwardA=10 with `exm.alu_result`=0x100, forwardB=01 with `w_result`=0x20, SUB → result 0xE0; rs=0 with forwardA=10 → srcA=0.
- **Load-use:** `stallE`=1, `flushM`=1 for one cycle → ID/EX unchanged and `exm.valid`=0. Next cycle forwardA=01 with `w_result`=0xDEAD, ADD imm 1 → result 0xDEAE.
- **Load data forwarding:** forwardB=11, `m_read_data`=0x55, `mem_write`=1, alu_src=1, imm=4, rs_val=0x1000 → alu_result=0x1004, write_data=0x55.
- **Arithmetic edges:**
  - SLT 0xFFFFFFFF vs 1 → 1; SLTU → 0.
  - ADD 0xFFFFFFFF+1 → 0.
  - SRA 0x80000000 by 4 → 0xF8000000.
  - LUI imm=0x1234 → 0x12340000.
- **Reset during stall:** reset asserted with `stallE`=1 → ID/EX and EX/MEM both cleared next cycle.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// Shared types for the execute stage: scalar aliases, ALU opcodes,
// forwarding select codes, hazard-unit controls and pipeline registers.
package execute_stage_pkg;

  typedef logic [31:0] u32;
  typedef logic [4:0]  creg_addr_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_t;

  // Operand forwarding selects driven by the hazard unit
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;
  localparam logic [1:0] FWD_MRD = 2'b11;

  typedef struct packed {
    logic [1:0] forwardA;
    logic [1:0] forwardB;
    logic       stallF;
    logic       stallD;
    logic       stallE;
    logic       flushM;
  } hazard_data_t;

  typedef struct packed {
    logic       valid;
    u32         pc;
    creg_addr_t rs;
    creg_addr_t rt;
    u32         rs_val;
    u32         rt_val;
    u32         imm;
    logic [4:0] shamt;
    alu_op_t    alu_op;
    logic       alu_src;
    creg_addr_t write_reg;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
  } decode_bundle_t;

  // ID/EX holds exactly what decode hands over
  typedef decode_bundle_t idex_t;

  typedef struct packed {
    logic       valid;
    u32         pc;
    u32         alu_result;
    u32         write_data;
    creg_addr_t write_reg;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
  } exmem_t;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational ALU for the execute stage. Shifts act on src_b by shamt;
// LUI places the low immediate half in the upper word.
module alu
  import execute_stage_pkg::*;
(
  input  u32          src_a,
  input  u32          src_b,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm_lo,
  input  alu_op_t     alu_op,
  output u32          result
);

  // Opcode decode; unassigned opcodes give zero
  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:  result = src_a + src_b;
      ALU_SUB:  result = src_a - src_b;
      ALU_AND:  result = src_a & src_b;
      ALU_OR:   result = src_a | src_b;
      ALU_XOR:  result = src_a ^ src_b;
      ALU_NOR:  result = ~(src_a | src_b);
      ALU_SLT:  result = {31'b0, ($signed(src_a) < $signed(src_b))};
      ALU_SLTU: result = {31'b0, (src_a < src_b)};
      ALU_SLL:  result = src_b << shamt;
      ALU_SRL:  result = src_b >> shamt;
      ALU_SRA:  result = u32'($signed(src_b) >>> shamt);
      ALU_LUI:  result = {imm_lo, 16'h0000};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ID/EX register, operand forwarding, ALU and EX/MEM register.
// rsE/rtE/mem_to_reg_E feed the hazard unit, which closes the loop by
// returning forwarding selects and stall/flush controls.
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  hazard_data_t   hazard_data,
  input  decode_bundle_t dec,
  input  u32             w_result,
  input  u32             m_read_data,
  output creg_addr_t     rsE,
  output creg_addr_t     rtE,
  output logic           mem_to_reg_E,
  output exmem_t         exm
);

  idex_t idex;
  u32    fwd_a;
  u32    fwd_b;
  u32    src_b;
  u32    alu_result;

  // stallF/stallD belong to earlier stages
  logic unused_hazard;
  assign unused_hazard = hazard_data.stallF ^ hazard_data.stallD;

  // ID/EX: reset > stall hold > load; an invalid bundle loads with its side effects stripped
  always_ff @(posedge clk) begin
    if (reset) begin
      idex <= '0;
    end else if (!hazard_data.stallE) begin
      idex <= dec;
      if (!dec.valid) begin
        idex.reg_write  <= 1'b0;
        idex.mem_write  <= 1'b0;
        idex.mem_to_reg <= 1'b0;
      end
    end
  end

  // Operand forwarding; $zero always reads as zero whatever the select says
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    case (hazard_data.forwardA)
      FWD_REG: fwd_a = idex.rs_val;
      FWD_W:   fwd_a = w_result;
      FWD_M:   fwd_a = exm.alu_result;
      FWD_MRD: fwd_a = m_read_data;
      default: fwd_a = '0;
    endcase
    case (hazard_data.forwardB)
      FWD_REG: fwd_b = idex.rt_val;
      FWD_W:   fwd_b = w_result;
      FWD_M:   fwd_b = exm.alu_result;
      FWD_MRD: fwd_b = m_read_data;
      default: fwd_b = '0;
    endcase
    if (idex.rs == '0) fwd_a = '0;
    if (idex.rt == '0) fwd_b = '0;
  end

  // Store data is taken from fwd_b before the immediate mux
  assign src_b = idex.alu_src ? idex.imm : fwd_b;

  alu u_alu (
    .src_a  (fwd_a),
    .src_b  (src_b),
    .shamt  (idex.shamt),
    .imm_lo (idex.imm[15:0]),
    .alu_op (idex.alu_op),
    .result (alu_result)
  );

  // EX/MEM: reset > flush bubble > load; flush also wins while ID/EX is stalled
  always_ff @(posedge clk) begin
    if (reset || hazard_data.flushM) begin
      exm <= '0;
    end else begin
      exm.valid      <= idex.valid;
      exm.pc         <= idex.pc;
      exm.alu_result <= alu_result;
      exm.write_data <= fwd_b;
      exm.write_reg  <= idex.write_reg;
      exm.reg_write  <= idex.reg_write;
      exm.mem_to_reg <= idex.mem_to_reg;
      exm.mem_write  <= idex.mem_write;
    end
  end

  assign rsE          = idex.rs;
  assign rtE          = idex.rt;
  assign mem_to_reg_E = idex.mem_to_reg;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed scenarios followed by random traffic,
// every cycle compared against a cycle-level reference model.
module tb_execute_stage;
  import execute_stage_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  hazard_data_t   hz;
  decode_bundle_t dec;
  u32             w_result;
  u32             m_read_data;
  creg_addr_t     rsE;
  creg_addr_t     rtE;
  logic           mem_to_reg_E;
  exmem_t         exm;

  int total = 0;
  int bad   = 0;

  decode_bundle_t m_idex;
  exmem_t         m_exm;

  execute_stage dut (
    .clk          (clk),
    .reset        (reset),
    .hazard_data  (hz),
    .dec          (dec),
    .w_result     (w_result),
    .m_read_data  (m_read_data),
    .rsE          (rsE),
    .rtE          (rtE),
    .mem_to_reg_E (mem_to_reg_E),
    .exm          (exm)
  );

  always #5 clk = ~clk;

  function automatic u32 ref_alu(logic [3:0] op, u32 a, u32 b, logic [4:0] sh, u32 imm);
    logic [63:0] ext;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, (a < b)};
      4'd7:  return {31'b0, (a < b)};
      4'd8:  return b << sh;
      4'd9:  return b >> sh;
      4'd10: begin
        ext = {{32{b[31]}}, b} >> sh;
        return ext[31:0];
      end
      4'd11: return {imm[15:0], 16'h0000};
      default: return 32'h0;
    endcase
  endfunction

  function automatic u32 ref_fwd(logic [1:0] sel, creg_addr_t r, u32 regval);
    if (r == 5'd0) return 32'h0;
    case (sel)
      2'd0:    return regval;
      2'd1:    return w_result;
      2'd2:    return m_exm.alu_result;
      default: return m_read_data;
    endcase
  endfunction

  function automatic decode_bundle_t mk(logic v, creg_addr_t rs, creg_addr_t rt, u32 rsv, u32 rtv,
                                        u32 imm, logic [4:0] sh, logic [3:0] op, logic asrc,
                                        creg_addr_t wr, logic rw, logic m2r, logic mw);
    decode_bundle_t d;
    d.valid = v; d.pc = 32'h400 + {27'b0, rs}; d.rs = rs; d.rt = rt;
    d.rs_val = rsv; d.rt_val = rtv; d.imm = imm; d.shamt = sh;
    d.alu_op = alu_op_t'(op); d.alu_src = asrc; d.write_reg = wr;
    d.reg_write = rw; d.mem_to_reg = m2r; d.mem_write = mw;
    return d;
  endfunction

  task automatic check(string tag, u32 obs, u32 exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmp_all(string tag);
    check({tag, "_valid"},  32'(exm.valid),        32'(m_exm.valid));
    check({tag, "_pc"},     exm.pc,                m_exm.pc);
    check({tag, "_res"},    exm.alu_result,        m_exm.alu_result);
    check({tag, "_wdata"},  exm.write_data,        m_exm.write_data);
    check({tag, "_wreg"},   32'(exm.write_reg),    32'(m_exm.write_reg));
    check({tag, "_rw"},     32'(exm.reg_write),    32'(m_exm.reg_write));
    check({tag, "_m2r"},    32'(exm.mem_to_reg),   32'(m_exm.mem_to_reg));
    check({tag, "_mw"},     32'(exm.mem_write),    32'(m_exm.mem_write));
    check({tag, "_rsE"},    32'(rsE),              32'(m_idex.rs));
    check({tag, "_rtE"},    32'(rtE),              32'(m_idex.rt));
    check({tag, "_m2rE"},   32'(mem_to_reg_E),     32'(m_idex.mem_to_reg));
  endtask

  // One clock: predict the next pipeline contents from the current inputs,
  // advance, then compare the DUT against the prediction.
  task automatic step(string tag);
    decode_bundle_t n_idex;
    exmem_t         n_exm;
    u32             fa, fb;
    n_idex = m_idex;
    n_exm  = '0;
    if (reset) begin
      n_idex = '0;
    end else begin
      if (!hz.flushM) begin
        fa = ref_fwd(hz.forwardA, m_idex.rs, m_idex.rs_val);
        fb = ref_fwd(hz.forwardB, m_idex.rt, m_idex.rt_val);
        n_exm.valid      = m_idex.valid;
        n_exm.pc         = m_idex.pc;
        n_exm.alu_result = ref_alu(m_idex.alu_op, fa, m_idex.alu_src ? m_idex.imm : fb,
                                   m_idex.shamt, m_idex.imm);
        n_exm.write_data = fb;
        n_exm.write_reg  = m_idex.write_reg;
        n_exm.reg_write  = m_idex.reg_write;
        n_exm.mem_to_reg = m_idex.mem_to_reg;
        n_exm.mem_write  = m_idex.mem_write;
      end
      if (!hz.stallE) begin
        n_idex = dec;
        if (!dec.valid) begin
          n_idex.reg_write = 1'b0; n_idex.mem_write = 1'b0; n_idex.mem_to_reg = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    m_idex = n_idex;
    m_exm  = n_exm;
    cmp_all(tag);
  endtask

  // Present one op on rs=1/rt=2 with no forwarding; result lands two edges later
  task automatic run_op(string tag, logic [3:0] op, u32 a, u32 b, u32 imm, logic [4:0] sh,
                        logic asrc, u32 exp);
    hz = '0;
    dec = mk(1'b1, 5'd1, 5'd2, a, b, imm, sh, op, asrc, 5'd9, 1'b1, 1'b0, 1'b0);
    step({tag, "_ld"});
    dec = '0;
    step(tag);
    check({tag, "_lit"}, exm.alu_result, exp);
  endtask

  initial begin
    reset = 1'b1; hz = '0; dec = '0; w_result = '0; m_read_data = '0;
    m_idex = '0; m_exm = '0;
    #2;
    step("rst");
    check("rst_valid_lit", 32'(exm.valid), 32'h0);
    check("rst_res_lit", exm.alu_result, 32'h0);
    reset = 1'b0;

    // Plain ADD, then reset clears it
    dec = mk(1'b1, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 5'd0, 4'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    step("add_ld");
    dec = '0;
    step("add");
    check("add_res_lit", exm.alu_result, 32'd12);
    check("add_rw_lit", 32'(exm.reg_write), 32'd1);
    check("add_wreg_lit", 32'(exm.write_reg), 32'd3);
    reset = 1'b1;
    step("add_rst");
    check("add_rst_res_lit", exm.alu_result, 32'h0);
    check("add_rst_rw_lit", 32'(exm.reg_write), 32'h0);
    reset = 1'b0;

    // M/W forwarding: 0x100 sits in EX/MEM, 0x20 in W, SUB gives 0xE0
    dec = mk(1'b1, 5'd1, 5'd0, 32'h100, 32'h0, 32'h0, 5'd0, 4'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    step("fwd_ld1");
    dec = mk(1'b1, 5'd4, 5'd5, 32'h1, 32'h1, 32'h0, 5'd0, 4'd1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    step("fwd_ld2");
    dec = '0;
    hz.forwardA = 2'b10; hz.forwardB = 2'b01; w_result = 32'h20;
    step("fwd_sub");
    check("fwd_sub_lit", exm.alu_result, 32'hE0);
    hz = '0;
    dec = mk(1'b1, 5'd0, 5'd6, 32'h77, 32'd9, 32'h0, 5'd0, 4'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    step("r0_ld");
    dec = '0;
    hz.forwardA = 2'b10;
    step("r0");
    check("r0_lit", exm.alu_result, 32'd9);
    hz = '0;

    // Load-use: stall ID/EX with a bubble into M, then forward the load from W
    dec = mk(1'b1, 5'd1, 5'd0, 32'h10, 32'h0, 32'd4, 5'd0, 4'd0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0);
    step("lu_ld");
    dec = mk(1'b1, 5'd7, 5'd0, 32'h0, 32'h0, 32'd1, 5'd0, 4'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    step("lu_use");
    check("lu_m2rE_lit", 32'(mem_to_reg_E), 32'd0);
    check("lu_m2r_lit", 32'(exm.mem_to_reg), 32'd1);
    dec = mk(1'b1, 5'd9, 5'd10, 32'h5, 32'h6, 32'd0, 5'd0, 4'd2, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
    hz.stallE = 1'b1; hz.flushM = 1'b1;
    step("lu_stall");
    check("lu_hold_rs_lit", 32'(rsE), 32'd7);
    check("lu_bubble_lit", 32'(exm.valid), 32'd0);
    hz = '0; dec = '0;
    hz.forwardA = 2'b01; w_result = 32'hDEAD;
    step("lu_fwd");
    check("lu_fwd_lit", exm.alu_result, 32'hDEAE);
    check("lu_fwd_valid_lit", 32'(exm.valid), 32'd1);
    hz = '0;

    // Load data forwarded into store data, address from base + imm
    dec = mk(1'b1, 5'd2, 5'd3, 32'h1000, 32'h999, 32'd4, 5'd0, 4'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    step("st_ld");
    dec = '0;
    hz.forwardB = 2'b11; m_read_data = 32'h55;
    step("st");
    check("st_addr_lit", exm.alu_result, 32'h1004);
    check("st_wdata_lit", exm.write_data, 32'h55);
    check("st_mw_lit", 32'(exm.mem_write), 32'd1);
    hz = '0;

    // Arithmetic edges
    run_op("slt",  4'd6,  32'hFFFF_FFFF, 32'h1, 32'h0, 5'd0, 1'b0, 32'h1);
    run_op("sltu", 4'd7,  32'hFFFF_FFFF, 32'h1, 32'h0, 5'd0, 1'b0, 32'h0);
    run_op("wrap", 4'd0,  32'hFFFF_FFFF, 32'h1, 32'h0, 5'd0, 1'b0, 32'h0);
    run_op("sra",  4'd10, 32'h0, 32'h8000_0000, 32'h0, 5'd4, 1'b0, 32'hF800_0000);
    run_op("lui",  4'd11, 32'h0, 32'h0, 32'h1234, 5'd0, 1'b1, 32'h1234_0000);
    run_op("nor",  4'd5,  32'hF0F0_0000, 32'h0000_000F, 32'h0, 5'd0, 1'b0, 32'h0F0F_FFF0);
    run_op("undef", 4'd14, 32'h1234, 32'h5678, 32'h0, 5'd0, 1'b0, 32'h0);

    // Reset while stalled clears both registers
    dec = mk(1'b1, 5'd12, 5'd13, 32'h3, 32'h4, 32'h0, 5'd0, 4'd0, 1'b0, 5'd14, 1'b1, 1'b1, 1'b0);
    step("rs_ld1");
    step("rs_ld2");
    hz.stallE = 1'b1; reset = 1'b1;
    step("rs_stall");
    check("rs_stall_rsE_lit", 32'(rsE), 32'h0);
    check("rs_stall_valid_lit", 32'(exm.valid), 32'h0);
    check("rs_stall_m2rE_lit", 32'(mem_to_reg_E), 32'h0);
    reset = 1'b0; hz = '0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      dec = mk(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               $urandom, $urandom, $urandom, 5'($urandom), 4'($urandom), 1'($urandom),
               5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      hz.forwardA = 2'($urandom);
      hz.forwardB = 2'($urandom);
      hz.stallF   = 1'($urandom);
      hz.stallD   = 1'($urandom);
      hz.stallE   = ($urandom_range(0, 4) == 0);
      hz.flushM   = ($urandom_range(0, 5) == 0);
      w_result    = $urandom;
      m_read_data = $urandom;
      reset       = ($urandom_range(0, 40) == 0);
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
